sdram_arbiter: RTL and testbench
================================

// Module: sdram_arbiter
// PURPOSE
//  Shares the single SDRAM controller port between the CHR (PPU), PRG (CPU) and HOST (loader)
//  channels, and schedules auto-refresh. Sits between map_mux/loader and the SDRAM controller.
//  Fixed priority CHR > PRG > REFRESH > HOST; refresh is escalated to top priority when starved.
// PARAMETERS
//  ADDR_BITS    23  word address width on every channel and on the controller port
//  REFRESH_MAX  64  clk cycles a pending refresh may wait before it preempts all channels
// PORTS
//  clk           in   1          system clock; all logic on posedge
//  reset         in   1          asynchronous, active-high
//  req[3]        in   1 each     channel request level; idx 0=CHR 1=PRG 2=HOST
//  we[3]         in   1 each     1=write, 0=read; stable while req high
//  addr[3]       in   ADDR_BITS  word address; stable while req high
//  wdata[3]      in   8 each     write data; stable while req high
//  ack[3]        out  1 each     one-cycle completion pulse to the owning channel
//  rdata         out  8          read data, valid in the ack cycle (shared by all channels)
//  refresh_req   in   1          one-cycle pulse requesting one auto-refresh
//  ctl_valid     out  1          command to controller is valid
//  ctl_ready     in   1          controller accepts command when ctl_valid && ctl_ready
//  ctl_refresh   out  1          1=refresh command (ctl_we/addr/wdata ignored)
//  ctl_we        out  1          write command
//  ctl_addr      out  ADDR_BITS  command address
//  ctl_wdata     out  8          command write data
//  ctl_done      in   1          one-cycle pulse: accepted command finished
//  ctl_rdata     in   8          read data, valid with ctl_done
//  busy          out  1          1 whenever state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE; ack=0; rdata=0; ctl_valid=0; ctl_refresh=0; ctl_we=0; ctl_addr=0;
//   ctl_wdata=0; busy=0; refresh debt=0; starve counter=0. Reset mid-transaction aborts it
//   silently (no ack); the controller is reset by the same signal.
//  FSM: IDLE -> ISSUE -> WAIT -> IDLE.
//   IDLE: evaluate winner (below); if any, register grant + command fields, go ISSUE.
//   ISSUE: ctl_valid=1, fields held stable until ctl_ready; on handshake go WAIT.
//   WAIT: on ctl_done: if grant is a channel, ack[grant]=1 and rdata<=ctl_rdata (ack and rdata
//    registered: ack one cycle after ctl_done); if refresh, debt-=1. Go IDLE.
//  Winner in IDLE: starved (debt>0 && starve>=REFRESH_MAX) -> REFRESH; else CHR, PRG,
//   REFRESH (debt>0), HOST in that order. Channel with ack high this cycle is not eligible
//   (its req drops the cycle after ack).
//  Latency, idle arbiter, controller ready: req seen @t -> ctl_valid @t+1 -> ack @done+1.
//   Back-to-back: next grant evaluated in the cycle after ack.
//  Refresh debt: 2-bit saturating counter; +1 per refresh_req, saturates at 3 (extra pulses
//   dropped). Simultaneous refresh_req and refresh completion: debt unchanged.
//  Starve counter: counts clk cycles while debt>0, cleared when a refresh is issued or debt=0;
//   saturates at REFRESH_MAX.
//  Protocol rules (bench asserts): req must stay high until ack; we/addr/wdata stable while req;
//   ctl_done never without a prior accepted command. ack is one-hot or zero.
//  Channel dropping req before ack is a protocol violation; the granted command still
//   completes and the ack is still pulsed.
// STRUCTURE
//  sdram_arb_pkg: state_t enum {IDLE,ISSUE,WAIT}; grant_t enum {G_CHR,G_PRG,G_HOST,G_REF};
//   channel index localparams CH_CHR=0, CH_PRG=1, CH_HOST=2.
//  Single module; winner select is an always_comb block, no sub-module.
// TESTING
//  1 Single PRG read addr=0x12345, controller done 3 cyc after ready, ctl_rdata=0xA5
//    -> ctl_addr=0x12345, ctl_we=0, ack[1] @done+1, rdata=0xA5.
//  2 CHR, PRG, HOST req same cycle -> service order CHR, PRG, HOST; exactly 3 ack pulses.
//  3 refresh_req pulse while PRG active; CHR idle -> refresh issued after PRG ack, debt 1->0.
//  4 CHR req held continuously, debt=1 -> refresh issued at first IDLE with starve>=64.
//  5 Five refresh_req pulses, no grants -> debt saturates 3; exactly 3 refresh cmds issued.
//  6 Assert reset in WAIT of HOST write -> all outputs reset values, no ack; next req served.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM port arbiter: FSM states, grant owners and channel indices.
package sdram_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic [1:0] {G_CHR, G_PRG, G_HOST, G_REF} grant_t;

  localparam int CH_CHR  = 0;
  localparam int CH_PRG  = 1;
  localparam int CH_HOST = 2;

  // Ack vector for a completed grant; refresh completions are never acked.
  function automatic logic [2:0] grant_onehot(grant_t g);
    logic [2:0] oh;
    oh = 3'b000;
    case (g)
      G_CHR:   oh[CH_CHR]  = 1'b1;
      G_PRG:   oh[CH_PRG]  = 1'b1;
      G_HOST:  oh[CH_HOST] = 1'b1;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller port between CHR, PRG and HOST and schedules auto-refresh.
// Priority CHR > PRG > REFRESH > HOST, with refresh escalated to the top once starved.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_BITS   = 23,
  parameter int REFRESH_MAX = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [2:0]                req,
  input  logic [2:0]                we,
  input  logic [2:0][ADDR_BITS-1:0] addr,
  input  logic [2:0][7:0]           wdata,
  output logic [2:0]                ack,
  output logic [7:0]                rdata,
  input  logic                      refresh_req,
  output logic                      ctl_valid,
  input  logic                      ctl_ready,
  output logic                      ctl_refresh,
  output logic                      ctl_we,
  output logic [ADDR_BITS-1:0]      ctl_addr,
  output logic [7:0]                ctl_wdata,
  input  logic                      ctl_done,
  input  logic [7:0]                ctl_rdata,
  output logic                      busy
);

  localparam int SW = $clog2(REFRESH_MAX + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(REFRESH_MAX);

  state_t          state;
  grant_t          grant;
  logic [1:0]      debt;
  logic [SW-1:0]   starve;

  logic [2:0]           elig;
  logic                 win_valid;
  grant_t               win;
  logic                 sel_we;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [7:0]           sel_wdata;
  logic                 issue_ref;
  logic                 ref_done;

  // A channel whose ack is on the wire still holds req this cycle; mask it out.
  always_comb begin
    elig      = req & ~ack;
    win_valid = 1'b1;
    win       = G_REF;
    if (debt != 2'd0 && starve >= STARVE_MAX) win = G_REF;
    else if (elig[CH_CHR])                    win = G_CHR;
    else if (elig[CH_PRG])                    win = G_PRG;
    else if (debt != 2'd0)                    win = G_REF;
    else if (elig[CH_HOST])                   win = G_HOST;
    else                                      win_valid = 1'b0;
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    case (win)
      G_CHR: begin
        sel_we    = we[CH_CHR];
        sel_addr  = addr[CH_CHR];
        sel_wdata = wdata[CH_CHR];
      end
      G_PRG: begin
        sel_we    = we[CH_PRG];
        sel_addr  = addr[CH_PRG];
        sel_wdata = wdata[CH_PRG];
      end
      G_HOST: begin
        sel_we    = we[CH_HOST];
        sel_addr  = addr[CH_HOST];
        sel_wdata = wdata[CH_HOST];
      end
      default: ;
    endcase
  end

  assign issue_ref = (state == IDLE) && win_valid && (win == G_REF);
  assign ref_done  = (state == WAIT) && ctl_done && (grant == G_REF);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= G_CHR;
      ack         <= '0;
      rdata       <= '0;
      ctl_valid   <= 1'b0;
      ctl_refresh <= 1'b0;
      ctl_we      <= 1'b0;
      ctl_addr    <= '0;
      ctl_wdata   <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (win_valid) begin
            grant       <= win;
            state       <= ISSUE;
            ctl_valid   <= 1'b1;
            ctl_refresh <= (win == G_REF);
            ctl_we      <= sel_we;
            ctl_addr    <= sel_addr;
            ctl_wdata   <= sel_wdata;
          end
        end
        ISSUE: begin
          if (ctl_ready) begin
            ctl_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (ctl_done) begin
            state <= IDLE;
            if (grant != G_REF) begin
              ack   <= grant_onehot(grant);
              rdata <= ctl_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A pulse arriving in the same cycle a refresh retires cancels out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      debt   <= 2'd0;
      starve <= '0;
    end else begin
      if (refresh_req && !ref_done) begin
        if (debt != 2'd3) debt <= debt + 2'd1;
      end else if (ref_done && !refresh_req) begin
        debt <= debt - 2'd1;
      end
      if (debt == 2'd0 || issue_ref) starve <= '0;
      else if (starve < STARVE_MAX)  starve <= starve + 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: behavioural reference model, controller/channel
// models with randomized timing, and directed scenarios with hand-computed expectations.
`timescale 1ns/1ps
module tb_sdram_arbiter;
  localparam int AB   = 23;
  localparam int RMAX = 64;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [2:0]          req;
  logic [2:0]          we;
  logic [2:0][AB-1:0]  addr;
  logic [2:0][7:0]     wdata;
  logic [2:0]          ack;
  logic [7:0]          rdata;
  logic                refresh_req;
  logic                ctl_valid;
  logic                ctl_ready;
  logic                ctl_refresh;
  logic                ctl_we;
  logic [AB-1:0]       ctl_addr;
  logic [7:0]          ctl_wdata;
  logic                ctl_done;
  logic [7:0]          ctl_rdata;
  logic                busy;

  sdram_arbiter #(.ADDR_BITS(AB), .REFRESH_MAX(RMAX)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .refresh_req(refresh_req), .ctl_valid(ctl_valid),
    .ctl_ready(ctl_ready), .ctl_refresh(ctl_refresh), .ctl_we(ctl_we),
    .ctl_addr(ctl_addr), .ctl_wdata(ctl_wdata), .ctl_done(ctl_done),
    .ctl_rdata(ctl_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // stimulus configuration, written by the main sequence at posedge
  bit          auto_en[3];
  int          rate[3];
  int          shot_req[3];
  logic        plan_we[3];
  logic [AB-1:0] plan_addr[3];
  logic [7:0]  plan_wdata[3];
  int          ref_shot_req = 0;
  bit          auto_ref = 0;
  int          ref_rate = 0;
  int          rdy_rate = 100;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          fix_rd_en = 0;
  logic [7:0]  fix_rd = 8'h00;

  // observations
  int          shot_done[3];
  bit          drop_next[3];
  int          raise_cyc[3];
  int          ref_shot_done = 0;
  int          ref_cyc = 0;
  int          done_cyc = 0;
  int          ref_issue_cyc = 0;
  int          n_ref = 0;
  int          ev_log[$];

  // channel + refresh-pulse driver
  initial begin : drv
    req = '0; we = '0; addr = '0; wdata = '0; refresh_req = 1'b0;
    for (int i = 0; i < 3; i++) begin shot_done[i] = 0; drop_next[i] = 0; raise_cyc[i] = 0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (drop_next[i]) begin
          req[i] = 1'b0;
          drop_next[i] = 1'b0;
        end else if (req[i]) begin
          if (ack[i]) drop_next[i] = 1'b1;
        end else if (shot_req[i] != shot_done[i]) begin
          req[i] = 1'b1; we[i] = plan_we[i]; addr[i] = plan_addr[i]; wdata[i] = plan_wdata[i];
          shot_done[i]++;
          raise_cyc[i] = cyc;
        end else if (auto_en[i] && $urandom_range(0, 99) < rate[i]) begin
          req[i] = 1'b1; we[i] = 1'($urandom_range(0, 1));
          addr[i] = AB'($urandom); wdata[i] = 8'($urandom);
          raise_cyc[i] = cyc;
        end
      end
      refresh_req = 1'b0;
      if (ref_shot_req != ref_shot_done) begin
        refresh_req = 1'b1; ref_shot_done++; ref_cyc = cyc;
      end else if (auto_ref && $urandom_range(0, 999) < ref_rate) begin
        refresh_req = 1'b1;
      end
    end
  end

  // SDRAM controller model and event monitor
  initial begin : ctl
    int done_cnt;
    done_cnt = 0;
    ctl_ready = 1'b0; ctl_done = 1'b0; ctl_rdata = 8'h00;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (ack[i]) ev_log.push_back(i);
      if (reset) begin
        done_cnt = 0; ctl_done = 1'b0; ctl_ready = 1'b0;
      end else begin
        ctl_done  = 1'b0;
        ctl_rdata = 8'($urandom);
        if (done_cnt > 0) begin
          done_cnt--;
          if (done_cnt == 0) begin
            ctl_done = 1'b1;
            if (fix_rd_en) ctl_rdata = fix_rd;
            done_cyc = cyc;
          end
        end
        ctl_ready = ($urandom_range(0, 99) < rdy_rate);
        if (ctl_valid && ctl_ready) begin
          done_cnt = $urandom_range(lat_min, lat_max);
          if (ctl_refresh) begin
            ev_log.push_back(3); ref_issue_cyc = cyc; n_ref++;
          end
        end
      end
    end
  end

  // behavioural reference: who owns the port, what must be on each output
  int           m_phase, m_owner, m_debt, m_starve;
  logic [2:0]   m_ack;
  logic [7:0]   m_rdata;
  bit           m_valid, m_ref;
  logic         m_we;
  logic [AB-1:0] m_addr;
  logic [7:0]   m_wdata;

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_debt = 0; m_starve = 0; m_ack = '0; m_rdata = '0;
    m_valid = 0; m_ref = 0; m_we = 0; m_addr = '0; m_wdata = '0;
  endtask

  initial begin : model
    int win;
    bit issue_ref, ref_fin;
    logic [2:0] nack;
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        model_reset();
      end else begin
        win = -1; issue_ref = 0; ref_fin = 0; nack = '0;
        if (m_phase == 0) begin
          if (m_debt > 0 && m_starve >= RMAX)  win = 3;
          else if (req[0] && !m_ack[0])        win = 0;
          else if (req[1] && !m_ack[1])        win = 1;
          else if (m_debt > 0)                 win = 3;
          else if (req[2] && !m_ack[2])        win = 2;
          if (win >= 0) begin
            m_phase = 1; m_owner = win; m_valid = 1; m_ref = (win == 3);
            issue_ref = (win == 3);
            if (win < 3) begin m_we = we[win]; m_addr = addr[win]; m_wdata = wdata[win]; end
          end
        end else if (m_phase == 1) begin
          if (ctl_ready) begin m_phase = 2; m_valid = 0; end
        end else begin
          if (ctl_done) begin
            m_phase = 0;
            if (m_owner == 3) ref_fin = 1;
            else begin nack[m_owner] = 1'b1; m_rdata = ctl_rdata; end
          end
        end
        if (m_debt == 0 || issue_ref) m_starve = 0;
        else if (m_starve < RMAX) m_starve++;
        if (refresh_req && !ref_fin) m_debt = (m_debt < 3) ? m_debt + 1 : 3;
        else if (ref_fin && !refresh_req) m_debt--;
        m_ack = nack;
      end
    end
  end

  // cycle-by-cycle comparison against the model
  initial begin : cmp
    forever begin
      @(negedge clk);
      chk("ack", 32'(ack), 32'(m_ack));
      chk("rdata", 32'(rdata), 32'(m_rdata));
      chk("ctl_valid", 32'(ctl_valid), 32'(m_valid));
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("ack_onehot0", 32'($onehot0(ack)), 32'd1);
      if (m_valid) begin
        chk("ctl_refresh", 32'(ctl_refresh), 32'(m_ref));
        if (!m_ref) begin
          chk("ctl_we", 32'(ctl_we), 32'(m_we));
          chk("ctl_addr", 32'(ctl_addr), 32'(m_addr));
          chk("ctl_wdata", 32'(ctl_wdata), 32'(m_wdata));
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"}, 32'(ack), 32'd0);
    chk({tag, "_rdata"}, 32'(rdata), 32'd0);
    chk({tag, "_valid"}, 32'(ctl_valid), 32'd0);
    chk({tag, "_refresh"}, 32'(ctl_refresh), 32'd0);
    chk({tag, "_we"}, 32'(ctl_we), 32'd0);
    chk({tag, "_addr"}, 32'(ctl_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(ctl_wdata), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || req != 0 || ack != 0 || refresh_req) && n < 400) begin
      @(negedge clk); n++;
    end
    repeat (3) @(negedge clk);
    chk(name, 32'(n < 400), 32'd1);
  endtask

  function automatic int ev_at(int k);
    return (ev_log.size() > k) ? ev_log[k] : 99;
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n, base, vcyc, diff;
    bit seen;
    for (int i = 0; i < 3; i++) begin
      auto_en[i] = 0; rate[i] = 0; shot_req[i] = 0;
      plan_we[i] = 0; plan_addr[i] = '0; plan_wdata[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: single PRG read
    @(posedge clk);
    rdy_rate = 100; lat_min = 3; lat_max = 3; fix_rd_en = 1; fix_rd = 8'hA5;
    plan_we[1] = 1'b0; plan_addr[1] = 23'h12345; plan_wdata[1] = 8'h3C; shot_req[1]++;
    n = 0;
    do begin @(negedge clk); n++; end while (!ctl_valid && n < 50);
    vcyc = cyc;
    chk("t1_valid_seen", 32'(n < 50), 32'd1);
    chk("t1_req_to_valid", 32'(vcyc - raise_cyc[1]), 32'd1);
    chk("t1_ctl_addr", 32'(ctl_addr), 32'h12345);
    chk("t1_ctl_we", 32'(ctl_we), 32'd0);
    n = 0;
    while (!ack[1] && n < 50) begin @(negedge clk); n++; end
    chk("t1_ack_seen", 32'(ack[1]), 32'd1);
    chk("t1_done_to_ack", 32'(cyc - done_cyc), 32'd1);
    chk("t1_done_after_issue", 32'(done_cyc - vcyc), 32'd3);
    chk("t1_rdata", 32'(rdata), 32'hA5);
    wait_idle("t1_idle");

    // 2: simultaneous CHR/PRG/HOST
    @(posedge clk);
    fix_rd_en = 0; rdy_rate = 50; lat_min = 1; lat_max = 4;
    ev_log.delete();
    for (int i = 0; i < 3; i++) begin
      plan_we[i] = 1'(i == 2); plan_addr[i] = AB'(32'h100 * (i + 1)); plan_wdata[i] = 8'(8'h11 * (i + 1));
      shot_req[i]++;
    end
    n = 0;
    while (ev_log.size() < 3 && n < 300) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    chk("t2_ack_count", 32'(ev_log.size()), 32'd3);
    chk("t2_first_chr", 32'(ev_at(0)), 32'd0);
    chk("t2_second_prg", 32'(ev_at(1)), 32'd1);
    chk("t2_third_host", 32'(ev_at(2)), 32'd2);
    wait_idle("t2_idle");

    // 3: refresh requested while PRG in flight
    @(posedge clk);
    rdy_rate = 100; lat_min = 3; lat_max = 3;
    ev_log.delete();
    plan_we[1] = 1'b0; plan_addr[1] = 23'h00777; shot_req[1]++;
    n = 0;
    while (!ctl_valid && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    ref_shot_req++;
    n = 0;
    while (ev_log.size() < 2 && n < 100) begin @(negedge clk); n++; end
    chk("t3_prg_first", 32'(ev_at(0)), 32'd1);
    chk("t3_refresh_next", 32'(ev_at(1)), 32'd3);
    wait_idle("t3_idle");

    // 4: refresh starved by continuous CHR/PRG traffic
    @(posedge clk);
    lat_min = 1; lat_max = 2; rdy_rate = 100;
    auto_en[0] = 1; auto_en[1] = 1; rate[0] = 100; rate[1] = 100;
    repeat (10) @(negedge clk);
    @(posedge clk);
    base = n_ref;
    ref_shot_req++;
    n = 0;
    while (n_ref == base && n < 300) begin @(negedge clk); n++; end
    diff = ref_issue_cyc - ref_cyc;
    chk("t4_refresh_issued", 32'(n_ref - base), 32'd1);
    chk("t4_waited_starve", 32'(diff >= RMAX), 32'd1);
    chk("t4_escalated", 32'(diff <= RMAX + 16), 32'd1);
    @(posedge clk);
    auto_en[0] = 0; auto_en[1] = 0;
    wait_idle("t4_idle");

    // 5: five back-to-back refresh pulses saturate the debt at 3
    @(posedge clk);
    lat_min = 6; lat_max = 6;
    base = n_ref;
    ref_shot_req += 5;
    repeat (120) @(negedge clk);
    chk("t5_refresh_count", 32'(n_ref - base), 32'd3);
    wait_idle("t5_idle");

    // 6: reset during WAIT of a HOST write
    @(posedge clk);
    lat_min = 8; lat_max = 8;
    plan_we[2] = 1'b1; plan_addr[2] = 23'h7ABCD; plan_wdata[2] = 8'h5A; shot_req[2]++;
    n = 0;
    while (!ctl_valid && n < 50) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    chk("t6_busy_in_wait", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    @(negedge clk);
    chk_reset_outputs("t6");
    seen = 0;
    repeat (10) begin @(negedge clk); if (ack != 0) seen = 1; end
    chk("t6_no_ack_in_reset", 32'(seen), 32'd0);
    #2 reset = 1'b0;
    n = 0;
    while (!ack[2] && n < 60) begin @(negedge clk); n++; end
    chk("t6_host_served_after_reset", 32'(ack[2]), 32'd1);
    wait_idle("t6_idle");

    // randomized traffic with occasional resets
    @(posedge clk);
    ev_log.delete();
    rdy_rate = 60; lat_min = 1; lat_max = 5;
    rate[0] = 25; rate[1] = 20; rate[2] = 15;
    auto_en[0] = 1; auto_en[1] = 1; auto_en[2] = 1;
    auto_ref = 1; ref_rate = 30;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 1499) == 0) begin
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
      end
    end
    @(posedge clk);
    auto_en[0] = 0; auto_en[1] = 0; auto_en[2] = 0; auto_ref = 0;
    wait_idle("rand_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
